// File: rtl/fpu_divider_iterative.sv
// Iterative IEEE-754-style divider (out = a / b), restoring mantissa division, flush-to-zero.
// Optional feature macro FPU_DIV_FLAGS_EN: when defined, exception flags are produced; otherwise flags is tied to 0.
module fpu_divider_iterative #(
  parameter int TOTAL_WIDTH = 32,
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] a,
  input  logic [TOTAL_WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] out,
  output logic [4:0]             flags
);

  localparam int N  = MANT_WIDTH + 3;
  localparam int EW = EXP_WIDTH + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic [TOTAL_WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_NORM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [TOTAL_WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [MANT_WIDTH+1:0]  rem_q, rem_d;
  logic [MANT_WIDTH:0]    dvs_q, dvs_d;
  logic [N-1:0]           quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [EXP_WIDTH-1:0]   ea, eb;
  logic [MANT_WIDTH-1:0]  fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;

  assign ea     = a_q[TOTAL_WIDTH-2 -: EXP_WIDTH];
  assign eb     = b_q[TOTAL_WIDTH-2 -: EXP_WIDTH];
  assign fa     = a_q[MANT_WIDTH-1:0];
  assign fb     = b_q[MANT_WIDTH-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign sgn    = a_q[TOTAL_WIDTH-1] ^ b_q[TOTAL_WIDTH-1];

  // One restoring step: the remainder is always below twice the divisor
  logic                  ge;
  logic [MANT_WIDTH+1:0] diff;
  assign ge   = rem_q >= {1'b0, dvs_q};
  assign diff = ge ? rem_q - {1'b0, dvs_q} : rem_q;

  logic [MANT_WIDTH-1:0] frac, frac_r;
  logic [MANT_WIDTH:0]   mant_r;
  logic                  g, r, st, up, ovf, unf;
  logic signed [EW-1:0]  e_n, e_r;

  always_comb begin
    if (quo_q[N-1]) begin
      frac = quo_q[N-2:2];
      g    = quo_q[1];
      r    = quo_q[0];
      e_n  = exp_q;
    end else begin
      frac = quo_q[N-3:1];
      g    = quo_q[0];
      r    = 1'b0;
      e_n  = exp_q - ONE;
    end
    st     = |rem_q;
    up     = g & (r | st | frac[0]);
    mant_r = {1'b0, frac} + (MANT_WIDTH+1)'(up);
    if (mant_r[MANT_WIDTH]) begin
      frac_r = '0;
      e_r    = e_n + ONE;
    end else begin
      frac_r = mant_r[MANT_WIDTH-1:0];
      e_r    = e_n;
    end
    ovf = e_r >= EMAX;
    unf = e_r[EW-1] || (e_r == '0);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        state_d = S_PREP;
      end
      S_PREP: begin
        sign_d  = sgn;
        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
        rem_d   = {2'b01, fa};
        dvs_d   = {1'b1, fb};
        quo_d   = '0;
        cnt_d   = CW'(N);
        state_d = S_DIV;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          out_d   = QNAN;
          state_d = S_DONE;
        end else if (b_zero || a_inf) begin
          out_d   = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          state_d = S_DONE;
        end else if (b_inf || a_zero) begin
          out_d   = {sgn, {(TOTAL_WIDTH-1){1'b0}}};
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = {diff[MANT_WIDTH:0], 1'b0};
        quo_d = {quo_q[N-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (ovf)      out_d = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        else if (unf) out_d = {sign_q, {(TOTAL_WIDTH-1){1'b0}}};
        else          out_d = {sign_q, e_r[EXP_WIDTH-1:0], frac_r};
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

`ifdef FPU_DIV_FLAGS_EN
  logic [4:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (state_q == S_PREP) begin
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) flags_d = 5'b10000;
      else if (b_zero && !a_inf)                                     flags_d = 5'b01000;
      else                                                           flags_d = 5'b00000;
    end else if (state_q == S_NORM) begin
      flags_d = {2'b00, ovf, unf, ovf | unf | g | r | st};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 5'b0;
`endif

endmodule

// File: tb/tb_fpu_divider_iterative.sv
// Randomized self-checking bench for fpu_divider_iterative against an arithmetic reference model.
module tb_fpu_divider_iterative;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic [4:0]  flags;
  int          n_cmp = 0;
  int          n_mis = 0;

`ifdef FPU_DIV_FLAGS_EN
  localparam logic [4:0] FMASK = 5'h1F;
`else
  localparam logic [4:0] FMASK = 5'h00;
`endif

  fpu_divider_iterative dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient from integer division of the scaled significands
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] o, output logic [4:0] f, output bit spc);
    int      ex, ey, e;
    longint  fx, fy, n, d, q, rm, mant;
    bit      s, xn, yn, xi, yi, xz, yz, g, r, sk, up;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = longint'(x[22:0]); fy = longint'(y[22:0]);
    s  = x[31] ^ y[31];
    xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
    xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
    xz = (ex == 0); yz = (ey == 0);
    spc = 1'b1;
    f   = 5'b0;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      o = 32'h7FC00000; f = 5'b10000;
    end else if (yz && !xi) begin
      o = {s, 8'hFF, 23'h0}; f = 5'b01000;
    end else if (xi) begin
      o = {s, 8'hFF, 23'h0};
    end else if (yi || xz) begin
      o = {s, 31'h0};
    end else begin
      spc = 1'b0;
      e  = ex - ey + 127;
      n  = (fx + 64'h800000) << 25;
      d  = fy + 64'h800000;
      q  = n / d;
      rm = n % d;
      if (q < (64'd1 << 25)) begin
        q = q << 1;
        e = e - 1;
      end
      g    = q[1];
      r    = q[0];
      sk   = (rm != 0);
      mant = q >> 2;
      up   = g && (r || sk || mant[0]);
      mant = mant + (up ? 1 : 0);
      if (mant >= (64'd1 << 24)) begin
        mant = 64'h800000;
        e    = e + 1;
      end
      if (e >= 255) begin
        o = {s, 8'hFF, 23'h0}; f = 5'b00101;
      end else if (e <= 0) begin
        o = {s, 31'h0}; f = 5'b00011;
      end else begin
        o = {s, e[7:0], mant[22:0]};
        f = (g || r || sk) ? 5'b00001 : 5'b00000;
      end
    end
  endfunction

  // Issue one operation and wait for its result; returns edges counted from the accept edge (inclusive)
  task automatic issue(input logic [31:0] x, input logic [31:0] y, output int lat);
    int w = 0;
    while (!in_ready && w < 60) begin
      tick();
      w++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = x; b = y;
    tick();
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eo;
    logic [4:0]  ef;
    bit          spc;
    int          lat;
    model(x, y, eo, ef, spc);
    issue(x, y, lat);
    check({tag, "_lat"}, 64'(lat), spc ? 64'd2 : 64'd29);
    check({tag, "_out"}, 64'(out), 64'(eo));
    check({tag, "_flags"}, 64'(flags), 64'(ef & FMASK));
    tick();
  endtask

  task automatic run_dir(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eo, input logic [4:0] ef, input int elat);
    int lat;
    issue(x, y, lat);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_out"}, 64'(out), 64'(eo));
    check({tag, "_flags"}, 64'(flags), 64'(ef & FMASK));
    tick();
  endtask

  function automatic logic [31:0] gen_operand();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    k = int'($urandom_range(0, 11));
    s = 1'($urandom);
    m = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin e = 8'd0;   m = m | 23'd1; end
      2: begin e = 8'hFF;  m = 23'd0; end
      3: begin e = 8'hFF;  m = m | 23'd1; end
      4: e = ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd254;
      5: e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if (k == 0) m = 23'd0;
    return {s, e, m};
  endfunction

  initial begin
    logic [31:0] hold_out;
    logic [4:0]  hold_flags;
    int          lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    run_dir("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);
    run_dir("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);
    run_dir("div_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2);
    run_dir("zero_zero",  32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 2);
    run_dir("inf_fin",    32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2);
    run_dir("overflow",   32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 5'b00101, 29);
    run_dir("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29);

    // Backpressure: result must hold and new requests be ignored
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40400000, lat);
    hold_out = out; hold_flags = flags;
    check("bp_out", 64'(hold_out), 64'h3EAAAAAB);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_valid = 1'b1; a = 32'h40C00000; b = 32'h40000000; end
      if (i == 4) in_valid = 1'b0;
      tick();
      check("bp_hold_out", 64'(out), 64'(hold_out));
      check("bp_hold_flags", 64'(flags), 64'(hold_flags));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    run_dir("after_bp", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);

    // Reset in the middle of the mantissa iterations
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out", 64'(out), 64'd0);
    check("mid_rst_flags", 64'(flags), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    run_dir("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);

    for (int i = 0; i < 250; i++) run_op("rand", gen_operand(), gen_operand());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
